// File: rtl/mux_pkg.sv
// Shared definitions for the N-way multiplexer family: the operating mode
// encoding used by mux_n_w_rr and its testbench.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search over N requesters. The pointer remembers the
// last channel served; the search starts just above it and wraps to 0.
module rr_arbiter #(
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [SEL_W-1:0] adv_idx,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  localparam int PAD_N = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [PAD_N-1:0] req_pad;

  assign req_pad = PAD_N'(req);

  // Reset to N-1 so that the very first search lands on channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SEL_W'(N - 1);
    end else if (advance) begin
      ptr <= adv_idx;
    end
  end

  always_comb begin
    int               cand;
    logic [SEL_W-1:0] cand_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = SEL_W'(cand);
      if (!grant_valid && req_pad[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mux_n_w_rr.sv
// N-channel, WIDTH-bit multiplexer with a single registered output stage.
// Channel choice is either a fixed select or round-robin over valid inputs.
module mux_n_w_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [SEL_W-1:0]   select,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready,
  output logic               sel_err
);

  localparam int PAD_N = 1 << SEL_W;

  mode_e            mode_q;
  logic             load_ok;
  logic             sel_legal;
  logic             fixed_valid;
  logic             rr_valid;
  logic             grant_valid;
  logic             xfer;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] grant_idx;
  logic [PAD_N-1:0] valid_pad;
  logic [WIDTH-1:0] grant_data;

  assign mode_q    = mode_e'(mode);
  assign load_ok   = !out_valid || out_ready;
  assign sel_legal = int'(select) < N;
  assign valid_pad = PAD_N'(in_valid);

  // Out-of-range selects read the zero padding, so they can never grant.
  assign fixed_valid = sel_legal && valid_pad[select];
  assign grant_valid = enable && ((mode_q == MODE_RR) ? rr_valid : fixed_valid);
  assign grant_idx   = (mode_q == MODE_RR) ? rr_idx : select;
  assign xfer        = rst_n && grant_valid && load_ok;
  assign in_ready    = xfer ? (N'(1) << grant_idx) : '0;

  rr_arbiter #(
    .N(N)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (in_valid),
    .advance    (xfer),
    .adv_idx    (grant_idx),
    .grant_valid(rr_valid),
    .grant_idx  (rr_idx)
  );

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(grant_idx) == i) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A drain and a fresh load may coincide; the load wins and keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= enable && (mode_q == MODE_FIXED) && !sel_legal;
    end
  end

endmodule

// File: tb/tb_mux_n_w_rr.sv
// Self-checking bench for mux_n_w_rr: a 4-channel instance driven from a vector
// table with a scoreboard, and a 3-channel instance for illegal-select cases.
module tb_mux_n_w_rr;

  typedef struct {
    logic       en;
    logic       md;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ord;
    logic [3:0] exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  chan;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic         en4, mode4, ord4, ovalid4, serr4;
  logic [1:0]   sel4, ochan4;
  logic [3:0]   vld4, rdy4;
  logic [127:0] data4;
  logic [31:0]  odata4;

  logic         en3, mode3, ord3, ovalid3, serr3;
  logic [1:0]   sel3, ochan3;
  logic [2:0]   vld3, rdy3;
  logic [95:0]  data3;
  logic [31:0]  odata3;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[23];

  always #5 clk = ~clk;

  mux_n_w_rr #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .mode(mode4), .select(sel4),
    .in_valid(vld4), .in_data(data4), .in_ready(rdy4), .out_valid(ovalid4),
    .out_data(odata4), .out_chan(ochan4), .out_ready(ord4), .sel_err(serr4)
  );

  mux_n_w_rr #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(en3), .mode(mode3), .select(sel3),
    .in_valid(vld3), .in_data(data3), .in_ready(rdy3), .out_valid(ovalid3),
    .out_data(odata3), .out_chan(ochan3), .out_ready(ord3), .sel_err(serr3)
  );

  function automatic logic [31:0] chan_data(input int k, input int i);
    if (k == 8 && i == 2) return 32'hDEADBEEF;
    return 32'(32'h0100_0000 * (k + 1) + i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of the 4-channel instance: drive, check handshake and held word, advance.
  task automatic applyStimulus(input logic en, input logic md, input logic [1:0] sel,
                               input logic [3:0] vld, input logic ord,
                               input logic [3:0] exp_rdy, input int k);
    exp_t e;
    en4 = en; mode4 = md; sel4 = sel; vld4 = vld; ord4 = ord;
    for (int i = 0; i < 4; i++) data4[i*32 +: 32] = chan_data(k, i);
    #1;
    checkOutput("in_ready4", 32'(rdy4), 32'(exp_rdy));
    checkOutput("out_valid4", 32'(ovalid4), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      checkOutput("out_data4", odata4, sb[0].data);
      checkOutput("out_chan4", 32'(ochan4), 32'(sb[0].chan));
      if (ord) void'(sb.pop_front());
    end
    if (exp_rdy != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_rdy[i]) begin
          e.data = chan_data(k, i);
          e.chan = 2'(i);
        end
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    checkOutput("sel_err4", 32'(serr4), 32'd0);
  endtask

  initial begin
    //                en    md    sel    vld      ord   exp_rdy
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001};
    vecs[7]  = '{1'b1, 1'b0, 2'd3, 4'b0101, 1'b1, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000};
    vecs[15] = '{1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010};
    vecs[16] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[17] = '{1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001};
    vecs[18] = '{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[19] = '{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vecs[20] = '{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vecs[21] = '{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vecs[22] = '{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};

    rst_n = 1'b0;
    en4 = 1'b1; mode4 = 1'b1; sel4 = 2'd0; vld4 = 4'b1111; ord4 = 1'b1; data4 = '0;
    en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; vld3 = 3'b000; ord3 = 1'b0;
    data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    #3;
    checkOutput("reset in_ready4", 32'(rdy4), 32'd0);
    checkOutput("reset out_valid4", 32'(ovalid4), 32'd0);
    checkOutput("reset out_data4", odata4, 32'd0);
    checkOutput("reset out_chan4", 32'(ochan4), 32'd0);
    checkOutput("reset sel_err4", 32'(serr4), 32'd0);
    checkOutput("reset out_valid3", 32'(ovalid3), 32'd0);
    repeat (2) @(posedge clk);
    en4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 23; k++) begin
      applyStimulus(vecs[k].en, vecs[k].md, vecs[k].sel, vecs[k].vld,
                    vecs[k].ord, vecs[k].exp_rdy, k);
    end

    // Reset arriving while a word is held must discard it at once.
    applyStimulus(1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 50);
    checkOutput("held before reset", 32'(ovalid4), 32'd1);
    checkOutput("held data before reset", odata4, chan_data(50, 1));
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid4", 32'(ovalid4), 32'd0);
    checkOutput("async reset out_data4", odata4, 32'd0);
    checkOutput("async reset out_chan4", 32'(ochan4), 32'd0);
    checkOutput("async reset in_ready4", 32'(rdy4), 32'd0);
    sb.delete();
    en4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 60);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 61);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 62);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 63);

    // Three-channel instance: a select of 3 addresses no channel.
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1; vld3 = 3'b010; ord3 = 1'b0;
    #1;
    checkOutput("n3 fixed in_ready", 32'(rdy3), 32'b010);
    @(posedge clk); #1;
    checkOutput("n3 load out_valid", 32'(ovalid3), 32'd1);
    checkOutput("n3 load out_chan", 32'(ochan3), 32'd1);
    checkOutput("n3 load out_data", odata3, 32'h3333_0001);
    checkOutput("n3 load sel_err", 32'(serr3), 32'd0);

    sel3 = 2'd3; vld3 = 3'b111;
    #1;
    checkOutput("n3 illegal in_ready", 32'(rdy3), 32'd0);
    @(posedge clk); #1;
    checkOutput("n3 illegal sel_err", 32'(serr3), 32'd1);
    checkOutput("n3 illegal out_valid", 32'(ovalid3), 32'd1);
    checkOutput("n3 illegal out_chan", 32'(ochan3), 32'd1);
    checkOutput("n3 illegal out_data", odata3, 32'h3333_0001);

    sel3 = 2'd0;
    #1;
    checkOutput("n3 full in_ready", 32'(rdy3), 32'd0);
    @(posedge clk); #1;
    checkOutput("n3 sel_err pulse end", 32'(serr3), 32'd0);
    checkOutput("n3 stall out_valid", 32'(ovalid3), 32'd1);

    mode3 = 1'b1; ord3 = 1'b1;
    #1;
    checkOutput("n3 rr after fixed in_ready", 32'(rdy3), 32'b100);
    @(posedge clk); #1;
    checkOutput("n3 rr out_chan", 32'(ochan3), 32'd2);
    checkOutput("n3 rr out_data", odata3, 32'h3333_0002);

    en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3;
    #1;
    checkOutput("n3 disabled in_ready", 32'(rdy3), 32'd0);
    @(posedge clk); #1;
    checkOutput("n3 disabled sel_err", 32'(serr3), 32'd0);
    checkOutput("n3 drain out_valid", 32'(ovalid3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
